// File: rtl/fw_hazard_unit.sv
// Forwarding select and load-use hazard detection between ID and the EX operand muxes.
// Tracks consecutive stall runs with a sticky error and keeps saturating perf counters.
module fw_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 3,
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0]  rs_i,
    input  logic [NUM_SRC-1:0]         rs_used_i,
    input  logic [NUM_FWD-1:0]         st_valid_i,
    input  logic [NUM_FWD*ADDR_W-1:0]  st_rd_i,
    input  logic [NUM_FWD-1:0]         st_wr_en_i,
    input  logic [NUM_FWD-1:0]         st_load_i,
    input  logic                       flush_i,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
    output logic                       stall_o,
    output logic                       hazard_err_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           fwd_cnt_o
);

    localparam int RUN_W = $clog2(LOAD_LAT + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOAD_LAT + 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

    state_t                      r_state;
    logic [RUN_W-1:0]            r_run;
    logic                        r_err;
    logic [NUM_SRC*SEL_W-1:0]    r_sel;
    logic [CNT_W-1:0]            r_stall_cnt;
    logic [CNT_W-1:0]            r_fwd_cnt;

    logic [NUM_SRC-1:0]            w_win_load;
    logic [NUM_SRC-1:0][SEL_W-1:0] w_win;
    logic                          w_stall;
    logic [NUM_SRC*SEL_W-1:0]      w_sel_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Per-source winner search: scanning oldest to youngest lets the youngest match overwrite.
    always_comb begin
        w_win      = '0;
        w_win_load = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                logic m;
                m = id_valid_i && rs_used_i[s]
                    && (rs_i[s*ADDR_W +: ADDR_W] != '0)
                    && st_valid_i[k] && st_wr_en_i[k]
                    && (st_rd_i[k*ADDR_W +: ADDR_W] == rs_i[s*ADDR_W +: ADDR_W]);
                w_win[s]      = m ? SEL_W'(k + 1) : w_win[s];
                w_win_load[s] = m ? (st_load_i[k] && (k < LOAD_LAT)) : w_win_load[s];
            end
        end
    end

    // Stall and next-select generation; a stalled or flushed cycle sends a bubble into EX.
    always_comb begin
        w_stall   = (|w_win_load) && !flush_i && !rst;
        w_sel_nxt = '0;
        if (rst || flush_i || w_stall) begin
            w_sel_nxt = '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                w_sel_nxt[s*SEL_W +: SEL_W] = w_win[s];
            end
        end
    end

    // Consecutive-stall FSM with sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_run   <= '0;
            r_err   <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_run   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_stall) begin
                        r_state <= S_STALL;
                        r_run   <= RUN_W'(1);
                    end
                end
                S_STALL: begin
                    if (w_stall) begin
                        if (r_run != RUN_MAX) begin
                            r_run <= r_run + RUN_W'(1);
                        end
                        if (r_run >= RUN_MAX - RUN_W'(1)) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_run   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_run   <= '0;
                end
            endcase
        end
    end

    // Registered forward selects and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= '0;
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            r_sel <= w_sel_nxt;
            if (w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (|w_sel_nxt) begin
                r_fwd_cnt <= sat_inc(r_fwd_cnt);
            end
        end
    end

    assign fwd_sel_o    = r_sel;
    assign stall_o      = w_stall;
    assign hazard_err_o = r_err;
    assign stall_cnt_o  = r_stall_cnt;
    assign fwd_cnt_o    = r_fwd_cnt;

endmodule

// File: tb/tb_fw_hazard_unit.sv
// Directed plus randomized bench for fw_hazard_unit against a behavioural reference model.
// Counters are narrowed so saturation is reachable in a short run.
module tb_fw_hazard_unit;

    localparam int NUM_SRC  = 2;
    localparam int NUM_FWD  = 3;
    localparam int ADDR_W   = 5;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 6;
    localparam int SEL_W    = $clog2(NUM_FWD + 1);
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                      clk;
    logic                      rst;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] rs;
    logic [NUM_SRC-1:0]        rs_used;
    logic [NUM_FWD-1:0]        st_valid;
    logic [NUM_FWD*ADDR_W-1:0] st_rd;
    logic [NUM_FWD-1:0]        st_wr_en;
    logic [NUM_FWD-1:0]        st_load;
    logic                      flush;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall;
    logic                      hazard_err;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          fwd_cnt;

    int vectors;
    int miscompares;

    // Reference model state (values the registered outputs must show after the next edge)
    int exp_sel[NUM_SRC];
    bit exp_err;
    int exp_scnt;
    int exp_fcnt;
    int run_len;

    fw_hazard_unit #(
        .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W),
        .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .rs_i(rs), .rs_used_i(rs_used),
        .st_valid_i(st_valid), .st_rd_i(st_rd), .st_wr_en_i(st_wr_en), .st_load_i(st_load),
        .flush_i(flush), .fwd_sel_o(fwd_sel), .stall_o(stall), .hazard_err_o(hazard_err),
        .stall_cnt_o(stall_cnt), .fwd_cnt_o(fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic clr_inputs();
        id_valid = 1'b0; rs = '0; rs_used = '0;
        st_valid = '0; st_rd = '0; st_wr_en = '0; st_load = '0;
        flush = 1'b0;
    endtask

    task automatic set_st(input int k, input int rd, input bit ld);
        st_valid[k] = 1'b1;
        st_wr_en[k] = 1'b1;
        st_load[k]  = ld;
        st_rd[k*ADDR_W +: ADDR_W] = ADDR_W'(rd);
    endtask

    task automatic set_rs(input int s, input int a);
        id_valid = 1'b1;
        rs_used[s] = 1'b1;
        rs[s*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    function automatic logic [31:0] packed_exp_sel();
        logic [31:0] p;
        p = '0;
        for (int s = 0; s < NUM_SRC; s++) p[s*SEL_W +: SEL_W] = SEL_W'(exp_sel[s]);
        return p;
    endfunction

    // One cycle: check the combinational stall, advance the model, clock, check registered outputs.
    task automatic step();
        int  win[NUM_SRC];
        bit  m_stall;
        bit  any_sel;
        #1;
        m_stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            int a;
            win[s] = -1;
            a = int'(rs[s*ADDR_W +: ADDR_W]);
            if (id_valid && rs_used[s] && a != 0) begin
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (win[s] < 0 && st_valid[k] && st_wr_en[k]
                        && int'(st_rd[k*ADDR_W +: ADDR_W]) == a) win[s] = k;
                end
            end
            if (win[s] >= 0 && win[s] < LOAD_LAT && st_load[win[s]]) m_stall = 1'b1;
        end
        if (rst || flush) m_stall = 1'b0;
        check("stall_o", 32'(stall), 32'(m_stall));

        if (rst) begin
            for (int s = 0; s < NUM_SRC; s++) exp_sel[s] = 0;
            exp_err = 1'b0; exp_scnt = 0; exp_fcnt = 0; run_len = 0;
        end else begin
            any_sel = 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                exp_sel[s] = (flush || m_stall) ? 0 : win[s] + 1;
                if (exp_sel[s] != 0) any_sel = 1'b1;
            end
            if (m_stall && exp_scnt < CNT_MAX) exp_scnt++;
            if (any_sel && exp_fcnt < CNT_MAX) exp_fcnt++;
            run_len = m_stall ? run_len + 1 : 0;
            if (run_len >= LOAD_LAT + 1) exp_err = 1'b1;
        end

        @(posedge clk);
        #1;
        check("fwd_sel_o", 32'(fwd_sel), packed_exp_sel());
        check("hazard_err_o", 32'(hazard_err), 32'(exp_err));
        check("stall_cnt_o", 32'(stall_cnt), 32'(exp_scnt));
        check("fwd_cnt_o", 32'(fwd_cnt), 32'(exp_fcnt));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int s = 0; s < NUM_SRC; s++) exp_sel[s] = 0;
        exp_err = 1'b0; exp_scnt = 0; exp_fcnt = 0; run_len = 0;
        clr_inputs();
        rst = 1'b1;
        step();
        step();
        check("reset_sel", 32'(fwd_sel), 32'h0);
        check("reset_cnt", 32'(stall_cnt) + 32'(fwd_cnt) + 32'(hazard_err), 32'h0);
        rst = 1'b0;

        // Same producer feeds both sources
        clr_inputs();
        set_st(0, 5, 1'b0);
        set_rs(0, 5); set_rs(1, 5);
        step();
        check("t1_sel", 32'(fwd_sel), 32'h5);
        check("t1_fwd_cnt", 32'(fwd_cnt), 32'd1);

        // Youngest producer wins; x0 never forwards
        clr_inputs();
        set_st(0, 7, 1'b0); set_st(2, 7, 1'b0);
        set_rs(0, 7);
        step();
        check("t2_youngest", 32'(fwd_sel), 32'h1);
        clr_inputs();
        set_st(0, 0, 1'b0);
        set_rs(0, 0);
        step();
        check("t2_x0", 32'(fwd_sel), 32'h0);

        // Load-use on rs2, then the load moves one stage older
        clr_inputs();
        set_st(0, 3, 1'b1);
        set_rs(1, 3);
        #1 check("t3_stall", 32'(stall), 32'd1);
        step();
        check("t3_bubble", 32'(fwd_sel), 32'h0);
        check("t3_scnt", 32'(stall_cnt), 32'd1);
        clr_inputs();
        set_st(1, 3, 1'b1);
        set_rs(1, 3);
        #1 check("t3_nostall", 32'(stall), 32'd0);
        step();
        check("t3_fwd_st1", 32'(fwd_sel), 32'h8);
        check("t3_no_err", 32'(hazard_err), 32'd0);

        // Two consecutive stalls overrun LOAD_LAT and latch the error
        clr_inputs();
        set_st(0, 3, 1'b1);
        set_rs(1, 3);
        step();
        step();
        check("t4_err", 32'(hazard_err), 32'd1);
        clr_inputs();
        step();
        check("t4_sticky", 32'(hazard_err), 32'd1);

        // Flush overrides a load-use hazard
        set_st(0, 3, 1'b1);
        set_rs(0, 3);
        flush = 1'b1;
        #1 check("t5_stall", 32'(stall), 32'd0);
        step();
        check("t5_scnt", 32'(stall_cnt), 32'd3);
        check("t5_sel", 32'(fwd_sel), 32'h0);
        flush = 1'b0;

        // Long stall drives the stall counter into saturation
        for (int i = 0; i < 70; i++) step();
        check("t6_sat", 32'(stall_cnt), 32'(CNT_MAX));
        rst = 1'b1;
        #1 check("t6_rst_stall", 32'(stall), 32'd0);
        step();
        check("t6_rst_all", 32'(fwd_sel) + 32'(hazard_err) + 32'(stall_cnt) + 32'(fwd_cnt), 32'h0);
        rst = 1'b0;

        // Randomized traffic on a small register window to force frequent matches
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            id_valid = ($urandom_range(0, 99) < 85);
            rs_used  = NUM_SRC'($urandom);
            for (int s = 0; s < NUM_SRC; s++) rs[s*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
            st_valid = NUM_FWD'($urandom);
            st_wr_en = NUM_FWD'($urandom | $urandom);
            for (int k = 0; k < NUM_FWD; k++) begin
                st_rd[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
                st_load[k] = ($urandom_range(0, 9) < 3);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
